// File: rtl/cla.sv
// Registered carry-lookahead adder, WIDTH in {4, 8, 12, 16}.
// The adder is built from 4-bit lookahead groups. A second-level lookahead
// unit combines the group generate/propagate terms. Sum, carry-out, group
// propagate, group generate and signed overflow are all registered.
// Optional macro CLA_INPUT_REG_EN adds an input register stage for
// a, b and cin, which makes the latency two cycles instead of one.
module cla #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             pg,
  output logic             gg,
  output logic             ovf
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;
  logic [NG-1:0]    w_grp_g;
  logic [NG-1:0]    w_grp_p;
  logic [NG:0]      w_gc;
  logic             w_gout;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_pg;
  logic             r_gg;
  logic             r_ovf;

`ifdef CLA_INPUT_REG_EN
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;

  // Operand capture stage; the lookahead logic sees only registered operands
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
    end else begin
      r_a   <= a;
      r_b   <= b;
      r_cin <= cin;
    end
  end

  assign w_a   = r_a;
  assign w_b   = r_b;
  assign w_cin = r_cin;
`else
  assign w_a   = a;
  assign w_b   = b;
  assign w_cin = cin;
`endif

  assign w_g = w_a & w_b;
  assign w_p = w_a ^ w_b;

  // Each group computes its internal carries from fully expanded equations.
  // The group's own carry-out comes from the second-level unit.
  for (genvar j = 0; j < NG; j++) begin : g_grp
    logic [3:0] w_gl;
    logic [3:0] w_pl;
    logic       w_ci;

    assign w_gl = w_g[4*j +: 4];
    assign w_pl = w_p[4*j +: 4];
    assign w_ci = w_gc[j];

    assign w_grp_g[j] = w_gl[3]
                      | (w_pl[3] & w_gl[2])
                      | (w_pl[3] & w_pl[2] & w_gl[1])
                      | (w_pl[3] & w_pl[2] & w_pl[1] & w_gl[0]);
    assign w_grp_p[j] = &w_pl;

    assign w_c[4*j]     = w_ci;
    assign w_c[4*j + 1] = w_gl[0]
                        | (w_pl[0] & w_ci);
    assign w_c[4*j + 2] = w_gl[1]
                        | (w_pl[1] & w_gl[0])
                        | (w_pl[1] & w_pl[0] & w_ci);
    assign w_c[4*j + 3] = w_gl[2]
                        | (w_pl[2] & w_gl[1])
                        | (w_pl[2] & w_pl[1] & w_gl[0])
                        | (w_pl[2] & w_pl[1] & w_pl[0] & w_ci);
  end

  // Second-level lookahead: each group carry is a flat sum of products
  // G[j] | P[j]G[j-1] | ... | P[j..0]cin. The cin-free term is the overall generate.
  always_comb begin
    logic v_acc;
    logic v_pr;
    w_gc    = '0;
    w_gc[0] = w_cin;
    w_gout  = 1'b0;
    v_acc   = 1'b0;
    v_pr    = 1'b1;
    for (int j = 0; j < NG; j++) begin
      v_acc = 1'b0;
      v_pr  = 1'b1;
      for (int k = j; k >= 0; k--) begin
        v_acc = v_acc | (w_grp_g[k] & v_pr);
        v_pr  = v_pr & w_grp_p[k];
      end
      w_gc[j+1] = v_acc | (v_pr & w_cin);
      if (j == NG - 1) begin
        w_gout = v_acc;
      end
    end
  end

  assign w_c[WIDTH] = w_gc[NG];

  // Output register stage; reset clears every result and wins over new operands
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_pg   <= 1'b0;
      r_gg   <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_sum  <= w_p ^ w_c[WIDTH-1:0];
      r_cout <= w_c[WIDTH];
      r_pg   <= &w_p;
      r_gg   <= w_gout;
      r_ovf  <= w_c[WIDTH-1] ^ w_c[WIDTH];
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign pg   = r_pg;
  assign gg   = r_gg;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_cla.sv
// Self-checking bench for cla: directed vector table at WIDTH=4, a reset
// sequence, and randomized streaming at WIDTH=4 and WIDTH=16 against an
// arithmetic reference model.
module tb_cla;

`ifdef CLA_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        pg;
    logic        gg;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       pg;
    logic       gg;
    logic       ovf;
  } vec_t;

  typedef struct {
    res_t e4;
    res_t e16;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a4, b4;
  logic        cin4;
  logic [3:0]  sum4;
  logic        cout4, pg4, gg4, ovf4;
  logic [15:0] a16, b16;
  logic        cin16;
  logic [15:0] sum16;
  logic        cout16, pg16, gg16, ovf16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .cout(cout4), .pg(pg4), .gg(gg4), .ovf(ovf4)
  );

  cla #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16),
    .sum(sum16), .cout(cout16), .pg(pg16), .gg(gg16), .ovf(ovf16)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: plain integer addition on the masked operands
  function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic ci);
    res_t r;
    logic [31:0] mask, am, bm, full, gen;
    mask  = (32'd1 << w) - 32'd1;
    am    = {16'd0, a} & mask;
    bm    = {16'd0, b} & mask;
    full  = am + bm + {31'd0, ci};
    gen   = am + bm;
    r.sum  = full[15:0] & mask[15:0];
    r.cout = full[w];
    r.pg   = ((am ^ bm) == mask);
    r.gg   = gen[w];
    r.ovf  = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
    return r;
  endfunction

  task automatic chk4(input string nm, input res_t e);
    chk({nm, ".sum"},  16'(sum4),  e.sum);
    chk({nm, ".cout"}, 16'(cout4), 16'(e.cout));
    chk({nm, ".pg"},   16'(pg4),   16'(e.pg));
    chk({nm, ".gg"},   16'(gg4),   16'(e.gg));
    chk({nm, ".ovf"},  16'(ovf4),  16'(e.ovf));
  endtask

  task automatic chk16(input string nm, input res_t e);
    chk({nm, ".sum"},  sum16,       e.sum);
    chk({nm, ".cout"}, 16'(cout16), 16'(e.cout));
    chk({nm, ".pg"},   16'(pg16),   16'(e.pg));
    chk({nm, ".gg"},   16'(gg16),   16'(e.gg));
    chk({nm, ".ovf"},  16'(ovf16),  16'(e.ovf));
  endtask

  function automatic res_t mk(input logic [3:0] s, input logic co, input logic p,
                              input logic g, input logic o);
    res_t r;
    r.sum = 16'(s); r.cout = co; r.pg = p; r.gg = g; r.ovf = o;
    return r;
  endfunction

  vec_t  vecs[8];
  pair_t q[$];
  res_t  zero_r;

  initial begin
    // a, b, cin -> sum, cout, pg, gg, ovf (hand-derived)
    vecs[0] = '{4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'b0111, 4'b0111, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{4'b1001, 4'b0110, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{4'b1010, 4'b1010, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{4'b0111, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1};
    zero_r = mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state with non-zero operands present
    rst = 1'b1;
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk4("reset4", zero_r);
    chk16("reset16", zero_r);

    // Directed vector table
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a4 = vecs[i].a; b4 = vecs[i].b; cin4 = vecs[i].cin;
      repeat (LAT) @(posedge clk);
      #1;
      chk4($sformatf("vec%0d", i),
           mk(vecs[i].sum, vecs[i].cout, vecs[i].pg, vecs[i].gg, vecs[i].ovf));
    end

    // Reset while an addition is in flight, then recovery
    a4 = 4'b0111; b4 = 4'b0111; cin4 = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    chk4("pre_rst", mk(4'b1110, 1'b0, 1'b0, 1'b0, 1'b1));
    a4 = 4'b1111; b4 = 4'b1110; cin4 = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk4("in_rst", zero_r);
    rst = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    chk4("post_rst", mk(4'b1101, 1'b1, 1'b0, 1'b1, 1'b0));

    // Randomized back-to-back stream, one new operand set per cycle
    q.delete();
    for (int i = 0; i < 300; i++) begin
      pair_t pe;
      a16   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b16   = ($urandom_range(0, 7) == 0) ? ~a16 : 16'($urandom);
      cin16 = 1'($urandom);
      a4    = 4'($urandom);
      b4    = ($urandom_range(0, 5) == 0) ? ~a4 : 4'($urandom);
      cin4  = 1'($urandom);
      pe.e4  = model(4, 16'(a4), 16'(b4), cin4);
      pe.e16 = model(16, a16, b16, cin16);
      q.push_back(pe);
      @(posedge clk);
      #1;
      if (q.size() == LAT) begin
        pair_t ce;
        ce = q.pop_front();
        chk4($sformatf("rnd4_%0d", i), ce.e4);
        chk16($sformatf("rnd16_%0d", i), ce.e16);
      end
    end
    while (q.size() > 0) begin
      pair_t ce;
      @(posedge clk);
      #1;
      ce = q.pop_front();
      chk4("rnd4_drain", ce.e4);
      chk16("rnd16_drain", ce.e16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cla.md
CLA -- requirements
Module: cla

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits; legal values 4, 8, 12, 16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port a  input  WIDTH  addend A, unsigned or two's complement.
REQ-005 SHALL have port b  input  WIDTH  addend B.
REQ-006 SHALL have port cin  input  1  carry in.
REQ-007 SHALL have port sum  output  WIDTH  registered sum.
REQ-008 SHALL have port cout  output  1  registered carry out of the MSB.
REQ-009 SHALL have port pg  output  1  registered group propagate (AND of all bit propagates).
REQ-010 SHALL have port gg  output  1  registered group generate (carry out when cin=0).
REQ-011 SHALL have port ovf  output  1  registered signed overflow.
REQ-012 SHALL be clocked by the single clock clk, with synchronous active-high reset rst.

Function
REQ-013 SHALL compute {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), no truncation of the carry.
REQ-014 SHALL form per-bit g[i] = a[i]&b[i] and p[i] = a[i]^b[i]; sum[i] = p[i]^c[i], c[0] = cin.
REQ-015 SHALL derive every carry inside each 4-bit group from fully expanded lookahead equations (c1..c4 from g, p, group carry-in), with no bit-to-bit ripple.
REQ-016 SHALL combine 4-bit groups via a second-level lookahead unit using group P/G; no ripple between groups.
REQ-017 SHALL set pg = AND of all p[i] and gg = carry out computed with cin forced to 0.
REQ-018 SHALL set ovf = c[WIDTH-1] XOR c[WIDTH] (carry into MSB XOR carry out).
REQ-019 SHALL register sum, cout, pg, gg and ovf on the rising clk edge; latency one cycle from inputs sampled to outputs valid.
REQ-020 SHALL accept new operands every cycle (throughput one result per cycle, no handshake).
REQ-021 SHALL produce all-ones wrap: a = b = all ones, cin = 1 gives sum = all ones, cout = 1.
REQ-022 SHALL treat X-free inputs only; no internal state other than the output registers (and the optional input registers).

Reset
REQ-023 SHALL, when rst = 1 at a rising edge, clear sum, cout, pg, gg, ovf (and any input registers) to 0.
REQ-024 SHALL give reset priority over new operands in the same cycle; an addition in flight at reset is discarded.
REQ-025 SHALL resume normal operation on the first edge with rst = 0, producing the sum of the operands sampled at that edge.

Configuration
REQ-026 SHALL, when macro CLA_INPUT_REG_EN is defined, register a, b, cin before the lookahead logic, making latency two cycles.
REQ-027 SHALL, without CLA_INPUT_REG_EN, feed a, b, cin combinationally into the lookahead logic, with latency one cycle.

Verification (WIDTH = 4, latency counted per configuration)
REQ-028 SHALL check a=0001, b=0010, cin=0 -> sum=0011, cout=0, ovf=0.
REQ-029 SHALL check a=0111, b=0111, cin=0 -> sum=1110, cout=0, ovf=1.
REQ-030 SHALL check a=1111, b=1111, cin=1 -> sum=1111, cout=1, pg=0, gg=1, ovf=0.
REQ-031 SHALL check a=1001, b=0110, cin=1 -> sum=0000, cout=1, pg=1, gg=0.
REQ-032 SHALL check a=1010, b=1010, cin=1 -> sum=0101, cout=1, ovf=1.
REQ-033 SHALL check rst=1 asserted while a=1111, b=1110 applied -> all outputs 0 next edge; after release, sum=1101, cout=1.
